// File: rtl/m2_frame_arb_pkg.sv
// rtl/m2_frame_arb_pkg.sv - shared types and widths for the M2 frame arbiter
package m2_frame_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 16;

endpackage

// File: rtl/m2_frame_arb_rr_pick2.sv
// rtl/m2_frame_arb_rr_pick2.sv - two-way round-robin picker, one-hot grant
import m2_frame_arb_pkg::*;

module rr_pick2 (
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] gnt
);

    // last=1 means requester 1 was served most recently, so requester 0 goes first
    always_comb begin
        gnt = '0;
        if (last) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule

// File: rtl/m2_frame_arb.sv
// rtl/m2_frame_arb.sv - frame-granular round-robin arbiter in front of the count/align stage
import m2_frame_arb_pkg::*;

module m2_frame_arb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s0_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    output logic                  s0_axis_tready,
    input  logic [CNT_W-1:0]      s0_cnt_limit,
    input  logic                  s0_en,
    input  logic                  s1_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    output logic                  s1_axis_tready,
    input  logic [CNT_W-1:0]      s1_cnt_limit,
    input  logic                  s1_en,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    input  logic                  m_axis_tready,
    output logic                  start_sig,
    output logic [CNT_W-1:0]      cnt_limit,
    input  logic                  af,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      frames0,
    output logic [CNT_W-1:0]      frames1
);

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [CNT_W-1:0]     r_cnt_limit, w_cnt_limit_nxt;
    logic [CNT_W-1:0]     r_beat_cnt, w_beat_cnt_nxt;
    logic [CNT_W-1:0]     r_frames0, w_frames0_nxt;
    logic [CNT_W-1:0]     r_frames1, w_frames1_nxt;
    logic                 r_frame_done, w_frame_done_nxt;
    logic                 r_last, w_last_nxt;
    logic [NUM_REQ-1:0]   w_req;
    logic [NUM_REQ-1:0]   w_pick;
    logic                 w_accept;
    logic                 w_last_beat;

    // almost-full only gates new grants; a running frame is never throttled here
    assign w_req = af ? '0 : {s1_en & s1_axis_tvalid, s0_en & s0_axis_tvalid};

    rr_pick2 u_pick (
        .req  (w_req),
        .last (r_last),
        .gnt  (w_pick)
    );

    always_comb begin
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = s0_axis_tdata;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        if (r_state == RUN) begin
            if (r_grant[1]) begin
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tdata   = s1_axis_tdata;
                s1_axis_tready = m_axis_tready;
            end else begin
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tdata   = s0_axis_tdata;
                s0_axis_tready = m_axis_tready;
            end
        end
    end

    assign w_accept    = m_axis_tvalid & m_axis_tready;
    assign w_last_beat = w_accept & (r_beat_cnt == r_cnt_limit);
    assign start_sig   = m_axis_tvalid & (r_beat_cnt == '0);

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_cnt_limit_nxt  = r_cnt_limit;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_frames0_nxt    = r_frames0;
        w_frames1_nxt    = r_frames1;
        w_frame_done_nxt = 1'b0;
        w_last_nxt       = r_last;
        if (r_state == IDLE) begin
            if (|w_pick) begin
                w_state_nxt     = RUN;
                w_grant_nxt     = w_pick;
                w_cnt_limit_nxt = w_pick[1] ? s1_cnt_limit : s0_cnt_limit;
                w_beat_cnt_nxt  = '0;
            end
        end else begin
            if (w_accept) w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
            if (w_last_beat) begin
                w_state_nxt      = IDLE;
                w_grant_nxt      = '0;
                w_frame_done_nxt = 1'b1;
                w_last_nxt       = r_grant[1];
                if (r_grant[1]) w_frames1_nxt = r_frames1 + CNT_W'(1);
                else            w_frames0_nxt = r_frames0 + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_cnt_limit  <= '0;
            r_beat_cnt   <= '0;
            r_frames0    <= '0;
            r_frames1    <= '0;
            r_frame_done <= 1'b0;
            r_last       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_cnt_limit  <= w_cnt_limit_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_frames0    <= w_frames0_nxt;
            r_frames1    <= w_frames1_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_last       <= w_last_nxt;
        end
    end

    assign grant      = r_grant;
    assign cnt_limit  = r_cnt_limit;
    assign frame_done = r_frame_done;
    assign frames0    = r_frames0;
    assign frames1    = r_frames1;

endmodule

// File: tb/tb_m2_frame_arb.sv
// tb/tb_m2_frame_arb.sv - scoreboard bench for m2_frame_arb
module tb_m2_frame_arb;

    typedef struct {
        logic [31:0] data;
        logic        start;
        logic [1:0]  gnt;
        logic [15:0] lim;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] f0;
        logic [15:0] f1;
    } done_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s0_axis_tvalid, s1_axis_tvalid;
    logic [31:0] s0_axis_tdata, s1_axis_tdata;
    logic        s0_axis_tready, s1_axis_tready;
    logic [15:0] s0_cnt_limit, s1_cnt_limit;
    logic        s0_en, s1_en;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tready;
    logic        start_sig;
    logic [15:0] cnt_limit;
    logic        af;
    logic [1:0]  grant;
    logic        frame_done;
    logic [15:0] frames0, frames1;

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          mode = 0;
    logic        abort = 1'b0;
    logic        exp_done_next = 1'b0;
    logic [15:0] exp_f0 = '0;
    logic [15:0] exp_f1 = '0;
    beat_t       beat_q[$];
    done_t       done_q[$];

    m2_frame_arb #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tready (s0_axis_tready),
        .s0_cnt_limit   (s0_cnt_limit),
        .s0_en          (s0_en),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tready (s1_axis_tready),
        .s1_cnt_limit   (s1_cnt_limit),
        .s1_en          (s1_en),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tready  (m_axis_tready),
        .start_sig      (start_sig),
        .cnt_limit      (cnt_limit),
        .af             (af),
        .grant          (grant),
        .frame_done     (frame_done),
        .frames0        (frames0),
        .frames1        (frames1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic push_frame(input int id, input int lim, input logic [31:0] base);
        for (int b = 0; b <= lim; b++) begin
            beat_t e;
            e.data  = base + 32'(b);
            e.start = (b == 0);
            e.gnt   = (id == 0) ? 2'b01 : 2'b10;
            e.lim   = 16'(lim);
            e.last  = (b == lim);
            beat_q.push_back(e);
        end
        if (id == 0) exp_f0 = exp_f0 + 16'd1;
        else         exp_f1 = exp_f1 + 16'd1;
        done_q.push_back('{exp_f0, exp_f1});
    endtask

    task automatic run_src(input int id, input int nbeats, input logic [31:0] base);
        int b = 0;
        while (b < nbeats) begin
            @(negedge clk);
            if (abort) break;
            if (id == 0) begin s0_axis_tvalid = 1'b1; s0_axis_tdata = base + 32'(b); end
            else         begin s1_axis_tvalid = 1'b1; s1_axis_tdata = base + 32'(b); end
            #4;
            if (id == 0 && s0_axis_tready) b++;
            if (id == 1 && s1_axis_tready) b++;
        end
        if (!abort) @(negedge clk);
        if (id == 0) s0_axis_tvalid = 1'b0;
        else         s1_axis_tvalid = 1'b0;
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (acc_cnt < target) chk("wait_acc_timeout", 64'(acc_cnt), 64'(target));
    endtask

    task automatic wait_grant(input logic [1:0] g);
        int n = 0;
        while (grant !== g && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (grant !== g) chk("wait_grant_timeout", 64'(grant), 64'(g));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        beat_q.delete();
        done_q.delete();
        exp_f0 = '0;
        exp_f1 = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        chk({name, "_beats_left"}, 64'(beat_q.size()), 64'd0);
        chk({name, "_done_left"}, 64'(done_q.size()), 64'd0);
    endtask

    // downstream ready pattern: always, 50% random, or rare stalls
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (mode == 0)      m_axis_tready = 1'b1;
            else if (mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
            else                m_axis_tready = ($urandom_range(0, 31) != 0);
        end
    end

    initial begin
        beat_t e;
        done_t d;
        forever begin
            @(negedge clk);
            #4;
            if (!reset_n) begin
                exp_done_next = 1'b0;
                continue;
            end
            if (frame_done || exp_done_next) begin
                chk("frame_done_timing", 64'(frame_done), 64'(exp_done_next));
                if (frame_done) begin
                    chk("done_grant_idle", 64'(grant), 64'd0);
                    chk("done_tvalid_idle", 64'(m_axis_tvalid), 64'd0);
                    if (done_q.size() == 0) begin
                        chk("unexpected_frame_done", 64'd1, 64'd0);
                    end else begin
                        d = done_q.pop_front();
                        chk("frames0", 64'(frames0), 64'(d.f0));
                        chk("frames1", 64'(frames1), 64'(d.f1));
                    end
                end
            end
            exp_done_next = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                acc_cnt++;
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 64'(m_axis_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = beat_q.pop_front();
                    checks++;
                    if (m_axis_tdata !== e.data || start_sig !== e.start ||
                        grant !== e.gnt || cnt_limit !== e.lim) begin
                        errors++;
                        $display("FAIL beat actual=%0h/%0b/%0b/%0h required=%0h/%0b/%0b/%0h",
                                 m_axis_tdata, start_sig, grant, cnt_limit,
                                 e.data, e.start, e.gnt, e.lim);
                    end
                    exp_done_next = e.last;
                end
            end
        end
    end

    initial begin
        #(1_500_000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int target;
        reset_n = 1'b0;
        s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
        s0_axis_tdata = '0;    s1_axis_tdata = '0;
        s0_cnt_limit = '0;     s1_cnt_limit = '0;
        s0_en = 1'b0;          s1_en = 1'b0;
        af = 1'b0;

        repeat (3) @(negedge clk);
        #4;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_cnt_limit", 64'(cnt_limit), 64'd0);
        chk("rst_frames0", 64'(frames0), 64'd0);
        chk("rst_frames1", 64'(frames1), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_s0_tready", 64'(s0_axis_tready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // single requester, 4-beat frame
        s0_en = 1'b1;
        s0_cnt_limit = 16'd3;
        push_frame(0, 3, 32'h10);
        run_src(0, 4, 32'h10);
        drain("t1");
        chk("t1_frames0", 64'(frames0), 64'd1);
        chk("t1_cnt_limit_hold", 64'(cnt_limit), 64'd3);

        // both continuously valid: grants alternate 0,1,0,1
        do_reset();
        s1_en = 1'b1;
        s0_cnt_limit = 16'd1;
        s1_cnt_limit = 16'd2;
        push_frame(0, 1, 32'h100);
        push_frame(1, 2, 32'h200);
        push_frame(0, 1, 32'h102);
        push_frame(1, 2, 32'h203);
        fork
            run_src(0, 4, 32'h100);
            run_src(1, 6, 32'h200);
        join
        drain("t2");

        // almost-full blocks grants but not a running frame
        s0_cnt_limit = 16'd3;
        af = 1'b1;
        s0_axis_tdata = 32'h20;
        s0_axis_tvalid = 1'b1;
        repeat (10) @(negedge clk);
        #4;
        chk("af_no_grant", 64'(grant), 64'd0);
        chk("af_no_tvalid", 64'(m_axis_tvalid), 64'd0);
        push_frame(0, 3, 32'h20);
        target = acc_cnt + 1;
        af = 1'b0;
        fork
            run_src(0, 4, 32'h20);
            begin
                wait_acc(target);
                @(negedge clk);
                af = 1'b1;
            end
        join
        s1_cnt_limit = 16'd1;
        push_frame(1, 1, 32'h30);
        fork
            run_src(1, 2, 32'h30);
            begin
                repeat (10) @(negedge clk);
                #4;
                chk("af_hold_grant", 64'(grant), 64'd0);
                chk("af_hold_tvalid", 64'(m_axis_tvalid), 64'd0);
                @(negedge clk);
                af = 1'b0;
            end
        join
        drain("t3");

        // limit change and enable drop mid-frame are ignored until frame end
        mode = 1;
        s1_cnt_limit = 16'd5;
        s1_en = 1'b1;
        push_frame(1, 5, 32'h40);
        fork
            run_src(1, 6, 32'h40);
            begin
                wait_grant(2'b10);
                repeat (2) @(negedge clk);
                s1_cnt_limit = 16'd1;
                s1_en = 1'b0;
            end
        join
        mode = 0;
        drain("t4");
        s1_axis_tvalid = 1'b1;
        repeat (10) @(negedge clk);
        #4;
        chk("t4_no_regrant", 64'(grant), 64'd0);
        @(negedge clk);
        s1_axis_tvalid = 1'b0;

        // maximum frame: 65536 beats with stalls
        s0_cnt_limit = 16'hFFFF;
        push_frame(0, 65535, 32'h1000_0000);
        fork
            run_src(0, 65536, 32'h1000_0000);
            begin
                mode = 1;
                repeat (400) @(negedge clk);
                mode = 2;
            end
        join
        mode = 0;
        drain("t5");
        chk("t5_frames0", 64'(frames0), 64'(exp_f0));

        // asynchronous reset mid-frame at beat 3 of 8
        s0_cnt_limit = 16'd7;
        push_frame(0, 7, 32'h400);
        target = acc_cnt + 3;
        fork
            run_src(0, 8, 32'h400);
            begin
                wait_acc(target);
                @(negedge clk);
                #2;
                reset_n = 1'b0;
                abort = 1'b1;
                beat_q.delete();
                done_q.delete();
                exp_f0 = '0;
                exp_f1 = '0;
                #1;
                chk("mid_rst_grant", 64'(grant), 64'd0);
                chk("mid_rst_frames0", 64'(frames0), 64'd0);
                chk("mid_rst_frames1", 64'(frames1), 64'd0);
                chk("mid_rst_cnt_limit", 64'(cnt_limit), 64'd0);
                @(negedge clk);
                reset_n = 1'b1;
            end
        join
        abort = 1'b0;
        s0_cnt_limit = 16'd0;
        s1_cnt_limit = 16'd0;
        s1_en = 1'b1;
        push_frame(0, 0, 32'h500);
        push_frame(1, 0, 32'h600);
        fork
            run_src(0, 1, 32'h500);
            run_src(1, 1, 32'h600);
        join
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m2_frame_arb.md
# m2_frame_arb

Frame-granular round-robin arbiter that shares one count/align stage of the M2 channelizer between two AXI-Stream requesters. It grants a whole frame at a time, drives the stage's `start_sig` and `cnt_limit` for the granted requester, and holds `cnt_limit` stable for the frame. It also stops new frames from starting while the downstream FIFO reports almost-full.

## Interface
- `DATA_WIDTH`, 32, stream data width
- `clk`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `s0_axis_tvalid`, `s1_axis_tvalid`  in  1  requester valid
- `s0_axis_tdata`, `s1_axis_tdata`  in  DATA_WIDTH  requester data
- `s0_axis_tready`, `s1_axis_tready`  out  1  requester ready
- `s0_cnt_limit`, `s1_cnt_limit`  in  16  per-requester frame length minus 1; sampled at grant
- `s0_en`, `s1_en`  in  1  requester enable; a disabled requester is never granted
- `m_axis_tvalid`  out  1  to count/align stage
- `m_axis_tdata`  out  DATA_WIDTH  to count/align stage
- `m_axis_tready`  in  1  from count/align stage
- `start_sig`  out  1  high with the first beat of each frame
- `cnt_limit`  out  16  latched limit of the current frame
- `af`  in  1  almost-full from the count/align stage
- `grant`  out  2  one-hot current owner; 0 when idle
- `frame_done`  out  1  one-cycle pulse after the last beat is accepted
- `frames0`, `frames1`  out  16  completed-frame counters; wrap at 0xFFFF→0

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: a grant is held.
- IDLE → RUN when `af`=0 and at least one requester has `sN_en`=1 and `sN_axis_tvalid`=1.
  - Winner is picked round-robin: the requester not served last has priority. After reset, requester 0 has priority.
  - On entry to RUN: `grant` is set, `cnt_limit` ← `sN_cnt_limit`, and `beat_cnt` ← 0.
- RUN: the datapath is a combinational mux of the granted requester.
  - `m_axis_tvalid` = `sN_axis_tvalid`.
  - `sN_axis_tready` = `m_axis_tready`.
  - The non-granted requester sees `tready` = 0.
  - A beat is accepted when `m_axis_tvalid` & `m_axis_tready`. Each accepted beat increments the 16-bit `beat_cnt`.
  - `start_sig` = `m_axis_tvalid` & (`beat_cnt`==0).
- Frame end: a beat accepted with `beat_cnt`==`cnt_limit` is the last beat. Next cycle:
  - state → IDLE, `grant` → 0;
  - `frame_done` pulses;
  - `framesN` increments;
  - the last-served pointer updates.
  - The frame length is `cnt_limit`+1 beats. `cnt_limit`=0 gives single-beat frames; 0xFFFF gives 65536 beats.
- `af` is checked only at grant time. A frame already in RUN completes regardless of `af`.
- Deasserting `sN_en` mid-frame has no effect until the frame ends.
- Changes to `sN_cnt_limit` during RUN are ignored.
- Output values in IDLE: `m_axis_tvalid`=0, `start_sig`=0, and both `tready`=0. `cnt_limit` holds its last value.
- Reset (asynchronous, any time):
  - state → IDLE, `grant`=0, `cnt_limit`=0, `beat_cnt`=0;
  - `frame_done`=0, `frames0`=`frames1`=0, priority → requester 0.
  - Any in-flight frame is dropped. The downstream stage must be reset alongside.

## Timing
- Grant latency: a request seen in IDLE gives `grant` in the next cycle. The first beat can then be accepted in that same RUN cycle.
- Back-to-back frames: one idle bubble between the last beat of one frame and the next grant.
- Data path: zero latency, purely combinational in RUN.
- `tvalid` is never withdrawn by this block mid-frame. Requesters must follow AXI-S rules.
- `frame_done` and the counter update occur one cycle after the final beat.
- If both requesters are continuously valid, grants alternate 0,1,0,1.

## Structure
- Package `m2_frame_arb_pkg`:
  - state enum {IDLE, RUN};
  - `NUM_REQ`=2;
  - `CNT_W`=16.
- Sub-module `rr_pick2`: combinational round-robin picker. Inputs: req[1:0], last[0]. Output: one-hot gnt[1:0].
- The top level contains the FSM, beat counter, limit latch, frame counters, and output mux.

## Test plan
- Only s0 valid, `s0_cnt_limit`=3, `m_axis_tready`=1 → 4 beats. `start_sig` on beat 0. `frame_done` one cycle after beat 3. `frames0`=1.
- Both valid continuously, limits 1/2 → grants 0,1,0,1 with frame lengths 2,3,2,3. One bubble cycle between frames.
- `af`=1 asserted before a request → no grant. `af`=1 raised mid-frame → frame completes, then no new grant until `af`=0.
- Random `m_axis_tready` stalls with `cnt_limit`=0xFFFF → exactly 65536 beats. Data order preserved, no loss or duplication.
- `s1_cnt_limit` changed and `s1_en` dropped mid-frame → current frame length unchanged. s1 is not re-granted afterwards.
- `reset_n` pulsed low mid-frame (limit 7, beat 3) → `grant`, `frames*`, and `cnt_limit` all read 0 immediately. The next grant goes to requester 0.
